// File: rtl/ghost_regfile_mp.sv
// Ghost register file for the microcode sequencer: two write ports (port 1 wins
// on a same-address collision), a per-register valid bit, and a background
// clear engine that zeroes one register per cycle with a busy/done handshake.
// Optional build macro: GHOST_BYPASS_EN forwards same-cycle write data to reads.
//
// Latency: writes commit at the rising edge; reads are combinational; a clear
//          keeps clr_busy high for DEPTH cycles, then clr_done pulses once.
// Backpressure: none; writes arriving while clr_busy=1 are silently dropped and
//          a clr_req arriving during a sweep or its done cycle is ignored.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   wr0_en/addr/data              write port 0
//   wr1_en/addr/data              write port 1 (wins same-address collisions)
//   rs1/rs2/rd_addr               read addresses
//   rs1/rs2/rd_data, *_vld        read data and valid bit of addressed register
//   clr_req, clr_busy, clr_done   clear request, sweep in progress, done pulse
//   wr_conflict                   both ports hit the same address last cycle
module ghost_regfile_mp #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr0_en,
   input  logic [ADDR_W-1:0] wr0_addr,
   input  logic [DATA_W-1:0] wr0_data,
   input  logic              wr1_en,
   input  logic [ADDR_W-1:0] wr1_addr,
   input  logic [DATA_W-1:0] wr1_data,
   input  logic [ADDR_W-1:0] rs1_addr,
   input  logic [ADDR_W-1:0] rs2_addr,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rs1_data,
   output logic [DATA_W-1:0] rs2_data,
   output logic [DATA_W-1:0] rd_data,
   output logic              rs1_vld,
   output logic              rs2_vld,
   output logic              rd_vld,
   input  logic              clr_req,
   output logic              clr_busy,
   output logic              clr_done,
   output logic              wr_conflict
);

   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] idx;
   logic [ADDR_W-1:0] idx_nxt;

   logic [DATA_W-1:0] regs [DEPTH];
   logic [DEPTH-1:0]  vld;

   assign clr_busy = (state == SWEEP);
   assign clr_done = (state == DONE);

   // ---------------- clear FSM ----------------
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      case (state)
         IDLE: begin
            if (clr_req) begin
               state_nxt = SWEEP;
               idx_nxt   = '0;
            end
         end
         SWEEP: begin
            // Stop on the last register instead of letting idx wrap to 0.
            if (idx == ADDR_W'(DEPTH - 1)) begin
               state_nxt = DONE;
            end else begin
               idx_nxt = idx + 1'b1;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
            idx_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         idx   <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
      end
   end

   // ---------------- storage ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
         vld <= '0;
      end else if (clr_busy) begin
         // The sweep owns the array; both write ports are ignored meanwhile.
         regs[idx] <= '0;
         vld[idx]  <= 1'b0;
      end else begin
         if (wr0_en) begin
            regs[wr0_addr] <= wr0_data;
            vld[wr0_addr]  <= 1'b1;
         end
         // Issued after port 0 so that port 1 wins on an address collision.
         if (wr1_en) begin
            regs[wr1_addr] <= wr1_data;
            vld[wr1_addr]  <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_conflict <= 1'b0;
      end else begin
         wr_conflict <= !clr_busy && wr0_en && wr1_en && (wr0_addr == wr1_addr);
      end
   end

   // ---------------- read ports ----------------
   for (genvar p = 0; p < 3; p++) begin : g_rd
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
      logic              v;

      assign a = (p == 0) ? rs1_addr : ((p == 1) ? rs2_addr : rd_addr);

      always_comb begin
         d = regs[a];
         v = vld[a];
`ifdef GHOST_BYPASS_EN
         // Forward the value that will be stored at the coming edge.
         if (!clr_busy && wr1_en && (wr1_addr == a)) begin
            d = wr1_data;
            v = 1'b1;
         end else if (!clr_busy && wr0_en && (wr0_addr == a)) begin
            d = wr0_data;
            v = 1'b1;
         end
`endif
      end
   end

   assign rs1_data = g_rd[0].d;
   assign rs2_data = g_rd[1].d;
   assign rd_data  = g_rd[2].d;
   assign rs1_vld  = g_rd[0].v;
   assign rs2_vld  = g_rd[1].v;
   assign rd_vld   = g_rd[2].v;

endmodule

// File: tb/tb_ghost_regfile_mp.sv
// Bench for ghost_regfile_mp: directed scenarios followed by random traffic,
// all compared against a behavioural model of the register bank.
module tb_ghost_regfile_mp;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr0_en, wr1_en;
   logic [3:0]  wr0_addr, wr1_addr;
   logic [31:0] wr0_data, wr1_data;
   logic [3:0]  rs1_addr, rs2_addr, rd_addr;
   logic [31:0] rs1_data, rs2_data, rd_data;
   logic        rs1_vld, rs2_vld, rd_vld;
   logic        clr_req;
   logic        clr_busy, clr_done, wr_conflict;

   int total = 0;
   int bad   = 0;

   // Behavioural model: plain arrays plus "which register the sweep is on".
   logic [31:0] m_data [16];
   logic        m_vld  [16];
   int          sweep_pos;  // -1 when no sweep is running
   logic        m_done;
   logic        m_conf;

   always #5 clk = ~clk;

   ghost_regfile_mp #(.DATA_W(32), .ADDR_W(4)) dut (
      .clk(clk), .rst(rst),
      .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
      .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
      .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_data(rd_data),
      .rs1_vld(rs1_vld), .rs2_vld(rs2_vld), .rd_vld(rd_vld),
      .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done),
      .wr_conflict(wr_conflict)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) begin
         m_data[i] = 32'h0;
         m_vld[i]  = 1'b0;
      end
      sweep_pos = -1;
      m_done    = 1'b0;
      m_conf    = 1'b0;
   endtask

   // What a read of address a should return right now.
   task automatic exp_rd(input logic [3:0] a, output logic [31:0] d, output logic v);
      d = m_data[a];
      v = m_vld[a];
`ifdef GHOST_BYPASS_EN
      if (sweep_pos < 0) begin
         if (wr1_en && wr1_addr == a) begin
            d = wr1_data;
            v = 1'b1;
         end else if (wr0_en && wr0_addr == a) begin
            d = wr0_data;
            v = 1'b1;
         end
      end
`endif
   endtask

   // Apply one rising edge to the model using the currently driven inputs.
   task automatic model_edge();
      logic busy;
      if (rst) begin
         model_reset();
      end else begin
         busy   = (sweep_pos >= 0);
         m_conf = !busy && wr0_en && wr1_en && (wr0_addr == wr1_addr);
         if (busy) begin
            m_data[sweep_pos] = 32'h0;
            m_vld[sweep_pos]  = 1'b0;
            if (sweep_pos == 15) begin
               sweep_pos = -1;
               m_done    = 1'b1;
            end else begin
               sweep_pos++;
            end
         end else begin
            if (wr0_en) begin
               m_data[wr0_addr] = wr0_data;
               m_vld[wr0_addr]  = 1'b1;
            end
            if (wr1_en) begin
               m_data[wr1_addr] = wr1_data;
               m_vld[wr1_addr]  = 1'b1;
            end
            if (m_done) m_done = 1'b0;           // done cycle ignores clr_req
            else if (clr_req) sweep_pos = 0;
         end
      end
   endtask

   task automatic check_all();
      logic [31:0] d;
      logic        v;
      exp_rd(rs1_addr, d, v);
      chk("rs1_data", rs1_data, d);
      chk("rs1_vld", {31'b0, rs1_vld}, {31'b0, v});
      exp_rd(rs2_addr, d, v);
      chk("rs2_data", rs2_data, d);
      chk("rs2_vld", {31'b0, rs2_vld}, {31'b0, v});
      exp_rd(rd_addr, d, v);
      chk("rd_data", rd_data, d);
      chk("rd_vld", {31'b0, rd_vld}, {31'b0, v});
      chk("clr_busy", {31'b0, clr_busy}, {31'b0, sweep_pos >= 0});
      chk("clr_done", {31'b0, clr_done}, {31'b0, m_done});
      chk("wr_conflict", {31'b0, wr_conflict}, {31'b0, m_conf});
   endtask

   // Inputs are driven at the falling edge; compare, then take a rising edge.
   task automatic tick();
      #1;
      check_all();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic quiet();
      rst = 1'b0; clr_req = 1'b0;
      wr0_en = 1'b0; wr0_addr = 4'd0; wr0_data = 32'h0;
      wr1_en = 1'b0; wr1_addr = 4'd0; wr1_data = 32'h0;
   endtask

   task automatic read_all();
      for (int i = 0; i < 16; i++) begin
         rs1_addr = 4'(i); rs2_addr = 4'(15 - i); rd_addr = 4'(i ^ 5);
         tick();
      end
   endtask

   int busy_cnt, done_cnt;

   initial begin
      quiet();
      rs1_addr = 4'd0; rs2_addr = 4'd0; rd_addr = 4'd0;
      rst = 1'b1;
      model_reset();
      @(negedge clk);
      tick();
      tick();
      rst = 1'b0;

      // 1: reset state
      read_all();

      // 2: two ports, different addresses
      wr0_en = 1'b1; wr0_addr = 4'd3; wr0_data = 32'hDEADBEEF;
      wr1_en = 1'b1; wr1_addr = 4'd5; wr1_data = 32'h12345678;
      tick();
      quiet();
      rs1_addr = 4'd3; rs2_addr = 4'd5;
      #1;
      chk("t2_rs1", rs1_data, 32'hDEADBEEF);
      chk("t2_rs2", rs2_data, 32'h12345678);
      chk("t2_vld", {30'b0, rs1_vld, rs2_vld}, 32'h3);
      chk("t2_conf", {31'b0, wr_conflict}, 32'h0);
      tick();

      // 3: same-address collision
      wr0_en = 1'b1; wr0_addr = 4'd7; wr0_data = 32'h1;
      wr1_en = 1'b1; wr1_addr = 4'd7; wr1_data = 32'h2;
      tick();
      quiet();
      rd_addr = 4'd7;
      #1;
      chk("t3_data", rd_data, 32'h2);
      chk("t3_conf_hi", {31'b0, wr_conflict}, 32'h1);
      tick();
      chk("t3_conf_lo", {31'b0, wr_conflict}, 32'h0);

      // 4: fill, sweep with dropped writes and an ignored re-request
      for (int i = 0; i < 8; i++) begin
         wr0_en = 1'b1; wr0_addr = 4'(2 * i);     wr0_data = $urandom | 32'h1;
         wr1_en = 1'b1; wr1_addr = 4'(2 * i + 1); wr1_data = $urandom | 32'h1;
         tick();
      end
      quiet();
      clr_req = 1'b1;
      tick();
      busy_cnt = 0;
      done_cnt = 0;
      for (int k = 1; k <= 20; k++) begin
         quiet();
         if (k == 3) begin
            wr0_en = 1'b1; wr0_addr = 4'd15; wr0_data = 32'hCAFEF00D;
         end
         if (k == 5) begin
            wr0_en = 1'b1; wr0_addr = 4'd0; wr0_data = 32'h0BADBEEF;
            wr1_en = 1'b1; wr1_addr = 4'd0; wr1_data = 32'h0BADD00D;
            clr_req = 1'b1;
         end
         rs1_addr = 4'(k % 16); rs2_addr = 4'd0; rd_addr = 4'd15;
         #1;
         if (clr_busy) busy_cnt++;
         if (clr_done) done_cnt++;
         tick();
      end
      chk("t4_busy_cycles", busy_cnt, 16);
      chk("t4_done_pulses", done_cnt, 1);
      read_all();

      // 5: reset in the middle of a sweep
      wr0_en = 1'b1; wr0_addr = 4'd9;  wr0_data = 32'h99;
      wr1_en = 1'b1; wr1_addr = 4'd14; wr1_data = 32'hEE;
      tick();
      quiet();
      clr_req = 1'b1;
      tick();
      quiet();
      for (int k = 0; k < 8; k++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("t5_busy", {31'b0, clr_busy}, 32'h0);
      chk("t5_done", {31'b0, clr_done}, 32'h0);
      tick();
      chk("t5_done2", {31'b0, clr_done}, 32'h0);
      read_all();

      // 6: same-cycle write and read
      wr0_en = 1'b1; wr0_addr = 4'd2; wr0_data = 32'h11111111;
      tick();
      wr0_data = 32'hA5A5A5A5;
      rd_addr = 4'd2;
      #1;
`ifdef GHOST_BYPASS_EN
      chk("t6_rd", rd_data, 32'hA5A5A5A5);
`else
      chk("t6_rd", rd_data, 32'h11111111);
`endif
      chk("t6_vld", {31'b0, rd_vld}, 32'h1);
      tick();
      quiet();
      #1;
      chk("t6_after", rd_data, 32'hA5A5A5A5);
      tick();

      // Random traffic
      for (int n = 0; n < 600; n++) begin
         rst      = ($urandom_range(0, 99) == 0);
         clr_req  = ($urandom_range(0, 19) == 0);
         wr0_en   = $urandom_range(0, 1) == 1;
         wr1_en   = $urandom_range(0, 1) == 1;
         wr0_addr = 4'($urandom);
         wr1_addr = ($urandom_range(0, 3) == 0) ? wr0_addr : 4'($urandom);
         wr0_data = $urandom;
         wr1_data = $urandom;
         rs1_addr = ($urandom_range(0, 2) == 0) ? wr0_addr : 4'($urandom);
         rs2_addr = ($urandom_range(0, 2) == 0) ? wr1_addr : 4'($urandom);
         rd_addr  = 4'($urandom);
         tick();
      end
      quiet();
      read_all();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/ghost_regfile_mp.md
Name: ghost_regfile_mp

Overview:
Parametrised multi-port ghost register file for the microcode sequencer. It replaces the fixed 16x32, single-write ghost bank.
- Adds a second write port with defined same-address priority.
- Keeps a per-register valid bit (written since last clear).
- Adds a multi-cycle background clear engine with busy/done handshake.
Sits beside the architectural register file and is driven only by the ucode controller.

Parameters:
DATA_W, 32, data width of each ghost register
ADDR_W, 4, address width; DEPTH = 2**ADDR_W registers (derived localparam, not overridable)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, synchronous, active-high
wr0_en  in  1  write port 0 enable
wr0_addr  in  ADDR_W  write port 0 address
wr0_data  in  DATA_W  write port 0 data
wr1_en  in  1  write port 1 enable (priority port)
wr1_addr  in  ADDR_W  write port 1 address
wr1_data  in  DATA_W  write port 1 data
rs1_addr, rs2_addr, rd_addr  in  ADDR_W each  read addresses
rs1_data, rs2_data, rd_data  out  DATA_W each  read data (combinational)
rs1_vld, rs2_vld, rd_vld  out  1 each  valid bit of the addressed register
clr_req  in  1  request full-bank clear
clr_busy  out  1  clear sweep in progress
clr_done  out  1  one-cycle pulse when sweep completes
wr_conflict  out  1  registered one-cycle pulse: both ports wrote the same address in the previous cycle

Behaviour:
Reset (rst=1 at an edge):
- All registers become 0 and all valid bits become 0.
- Clear FSM goes to IDLE; clr_busy=0, clr_done=0, wr_conflict=0.
- Reset overrides any write or sweep in the same cycle and aborts a sweep mid-operation.

Writes:
- At an edge with clr_busy=0, wrN_en=1 writes wrN_data to wrN_addr and sets that register's valid bit.
- Both ports enabled with equal addresses: port 1 data is stored; wr_conflict=1 for exactly the next cycle.
- Different addresses: both writes commit in the same cycle.
- While clr_busy=1, all writes are dropped (no data change, no valid set, no wr_conflict).

Reads:
- Combinational array lookup; the valid bit follows the same address.
- A read in the same cycle as a write to that address returns the old value (unless GHOST_BYPASS_EN).

Clear FSM, states IDLE, SWEEP, DONE:
- IDLE: clr_req=1 at an edge -> SWEEP with idx=0.
- SWEEP: each edge zeroes register[idx] and clears valid[idx]. If idx==DEPTH-1 -> DONE, else idx+1.
- DONE: one cycle, then IDLE.
- clr_busy = (state==SWEEP); clr_done = (state==DONE).
- clr_req in SWEEP or DONE is ignored (not queued).
- Timing: clr_req sampled at edge T gives clr_busy high for exactly DEPTH cycles and clr_done one cycle later.
- Reads during SWEEP return the partially cleared contents.
- idx is ADDR_W bits and never wraps past DEPTH-1.

Optional Feature:
Macro GHOST_BYPASS_EN.
- Defined: read ports forward same-cycle write data when the read address matches an enabled write address while clr_busy=0. Port 1 wins over port 0; the returned valid bit reads 1.
- Undefined: no forwarding; reads see pre-edge contents only.
- Write, conflict and clear behaviour are identical in both builds.

Test Plan:
1. Reset, then read all 16 addresses -> data 0, vld 0, clr_busy 0, wr_conflict 0.
2. wr0 addr3=0xDEADBEEF and wr1 addr5=0x12345678 in one cycle -> next cycle rs1(3)=0xDEADBEEF, rs2(5)=0x12345678, both vld=1, wr_conflict 0.
3. wr0 addr7=0x1, wr1 addr7=0x2 in one cycle -> addr7=0x2, wr_conflict high exactly one cycle.
4. Fill all registers, pulse clr_req -> clr_busy high 16 cycles; a wr0 to addr 15 issued on cycle 3 of the sweep is dropped; clr_done one pulse; all data 0 and vld 0. clr_req pulsed during the sweep -> no second sweep.
5. Start a sweep, assert rst at sweep cycle 8 -> next cycle state IDLE, clr_busy 0, no clr_done, all registers 0.
6. Same-cycle write/read of addr2=0xA5A5A5A5 -> rd_data shows the old value without GHOST_BYPASS_EN and 0xA5A5A5A5 with vld=1 with it.
